// File: rtl/mult_pkg.sv
// Shared types and helpers for the handshaked sequential multiplier.
// State encoding and counter sizing live here so control and bench agree.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width needed for a counter that must reach w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator and signed fixup.
// Control supplies load/step/last and the running bit index.
module mult_datapath #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic [CW-1:0]      count,
  output logic               shift_zero,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic               neg;

  // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
  assign mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign shift_zero = (mplr[WIDTH-1:1] == '0);

  always_comb begin
    addend = '0;
    if (mplr[0])
      addend = {{WIDTH{1'b0}}, mcand} << count;
    acc_next = acc + addend;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (load) begin
      mcand <= mag_a;
      mplr  <= mag_b;
      acc   <= '0;
      neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc  <= acc_next;
      mplr <= mplr >> 1;
      if (last)
        product <= neg ? -acc_next : acc_next;
    end
  end

endmodule

// File: rtl/seq_mult_hs.sv
// Handshaked sequential multiplier: FSM, bit counter and handshakes.
// Arithmetic is delegated to mult_datapath.
module seq_mult_hs
  import mult_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic          accept;
  logic          run;
  logic          last;
  logic          shift_zero;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign run       = (state == RUN);
  assign accept    = in_valid && in_ready;

  assign last = (count == CW'(WIDTH - 1))
             || ((EARLY_EXIT != 0) && shift_zero);

  always_comb begin
    state_next = state;
    unique case (1'b1)
      (state == IDLE): if (in_valid)  state_next = RUN;
      (state == RUN):  if (last)      state_next = DONE;
      (state == DONE): if (out_ready) state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (accept)
      count <= '0;
    else if (run)
      count <= count + CW'(1);
  end

  mult_datapath #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept),
    .step        (run),
    .last        (last),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .count       (count),
    .shift_zero  (shift_zero),
    .product     (product)
  );

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed and randomised bench for seq_mult_hs, WIDTH=8.
// Instance 0 runs full-length, instance 1 uses early exit.
module tb_seq_mult_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld   [2];
  logic        smode [2];
  logic        ordy  [2];
  logic        rdy   [2];
  logic        ovld  [2];
  logic        bsy   [2];
  logic [7:0]  opa   [2];
  logic [7:0]  opb   [2];
  logic [15:0] prod  [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_mult_hs #(.WIDTH(8), .EARLY_EXIT(0)) u_std (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (vld[0]),
    .in_ready    (rdy[0]),
    .a           (opa[0]),
    .b           (opb[0]),
    .signed_mode (smode[0]),
    .out_valid   (ovld[0]),
    .out_ready   (ordy[0]),
    .product     (prod[0]),
    .busy        (bsy[0])
  );

  seq_mult_hs #(.WIDTH(8), .EARLY_EXIT(1)) u_ee (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (vld[1]),
    .in_ready    (rdy[1]),
    .a           (opa[1]),
    .b           (opb[1]),
    .signed_mode (smode[1]),
    .out_valid   (ovld[1]),
    .out_ready   (ordy[1]),
    .product     (prod[1]),
    .busy        (bsy[1])
  );

  function automatic logic [15:0] ref_mul(
    input logic [7:0] x, input logic [7:0] y, input logic sm);
    logic [15:0] ex;
    logic [15:0] ey;
    ex = sm ? {{8{x[7]}}, x} : {8'd0, x};
    ey = sm ? {{8{y[7]}}, y} : {8'd0, y};
    return ex * ey;
  endfunction

  function automatic int ref_lat(input logic [7:0] y, input logic sm);
    logic [7:0] m;
    int l;
    m = (sm && y[7]) ? 8'(~y + 8'd1) : y;
    l = 1;
    for (int i = 0; i < 8; i++)
      if (m[i]) l = i + 1;
    return l;
  endfunction

  // Drive one op; p0 is sampled when out_valid first rises,
  // p when the result is actually taken.
  task automatic do_op(
    input int k, input logic [7:0] x, input logic [7:0] y,
    input logic sm, input int stall,
    output logic [15:0] p0, output logic [15:0] p,
    output int lat, output int bcnt, output bit to);
    int n;
    to = 1'b0;
    lat = 0;
    bcnt = 0;
    n = 0;
    ordy[k] = (stall == 0);
    while (!rdy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[k]) to = 1'b1;
    vld[k] = 1'b1;
    opa[k] = x;
    opb[k] = y;
    smode[k] = sm;
    @(negedge clk);
    vld[k] = 1'b0;
    opa[k] = 8'($urandom);
    opb[k] = 8'($urandom);
    smode[k] = 1'($urandom);
    while (!ovld[k] && lat < 40) begin
      if (bsy[k]) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (!ovld[k]) to = 1'b1;
    p0 = prod[k];
    for (int i = 0; i < stall; i++) begin
      bcnt++;
      @(negedge clk);
    end
    ordy[k] = 1'b1;
    p = prod[k];
    if (bsy[k]) bcnt++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (rdy[k] !== 1'b1 || ovld[k] !== 1'b0 || bsy[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_ctl[%0d]: got rdy=%b ov=%b busy=%b exp 1 0 0",
                 k, rdy[k], ovld[k], bsy[k]);
      end
      tests++;
      if (prod[k] !== 16'h0000) begin
        fails++;
        $display("FAIL reset_prod[%0d]: got %h exp 0000", k, prod[k]);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [15:0] p0, p;
    int lat, bcnt;
    bit to;
    logic [7:0] xs [3];
    logic [7:0] ys [3];
    logic [15:0] es [3];
    xs = '{8'd13, 8'd255, 8'd0};
    ys = '{8'd11, 8'd255, 8'd200};
    es = '{16'h008F, 16'hFE01, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      do_op(0, xs[i], ys[i], 1'b0, 0, p0, p, lat, bcnt, to);
      tests++;
      if (to || p !== es[i]) begin
        fails++;
        $display("FAIL unsigned_%0d: got %h exp %h (timeout=%0d)",
                 i, p, es[i], to);
      end
      tests++;
      if (lat != 8 || bcnt != 9) begin
        fails++;
        $display("FAIL unsigned_timing_%0d: got lat=%0d busy=%0d exp 8 9",
                 i, lat, bcnt);
      end
      tests++;
      if (ovld[0] !== 1'b0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
        fails++;
        $display("FAIL unsigned_after_%0d: got ov=%b busy=%b rdy=%b exp 0 0 1",
                 i, ovld[0], bsy[0], rdy[0]);
      end
    end
  endtask

  task automatic test_signed();
    logic [15:0] p0, p;
    int lat, bcnt;
    bit to;
    logic [7:0] xs [4];
    logic [7:0] ys [4];
    logic [15:0] es [4];
    xs = '{8'hFD, 8'h80, 8'h80, 8'h7F};
    ys = '{8'h05, 8'h80, 8'h7F, 8'hFF};
    es = '{16'hFFF1, 16'h4000, 16'hC080, 16'hFF81};
    for (int i = 0; i < 4; i++) begin
      do_op(0, xs[i], ys[i], 1'b1, 0, p0, p, lat, bcnt, to);
      tests++;
      if (to || p !== es[i] || p !== ref_mul(xs[i], ys[i], 1'b1)) begin
        fails++;
        $display("FAIL signed_%0d: got %h exp %h model %h",
                 i, p, es[i], ref_mul(xs[i], ys[i], 1'b1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] p0, p;
    int lat, bcnt, n;
    bit to;
    ordy[0] = 1'b0;
    n = 0;
    while (!rdy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    vld[0] = 1'b1;
    opa[0] = 8'd9;
    opb[0] = 8'd9;
    smode[0] = 1'b0;
    @(negedge clk);
    vld[0] = 1'b0;
    n = 0;
    while (!ovld[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!ovld[0]) begin
      fails++;
      $display("FAIL bp_wait: got out_valid=%b exp 1", ovld[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (prod[0] !== 16'h0051 || ovld[0] !== 1'b1 || rdy[0] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d: got p=%h ov=%b rdy=%b exp 0051 1 0",
                 i, prod[0], ovld[0], rdy[0]);
      end
      vld[0] = (i == 2);
      opa[0] = 8'd1;
      opb[0] = 8'd1;
      @(negedge clk);
    end
    vld[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (ovld[0] !== 1'b0 || rdy[0] !== 1'b1 || prod[0] !== 16'h0051) begin
      fails++;
      $display("FAIL bp_release: got ov=%b rdy=%b p=%h exp 0 1 0051",
               ovld[0], rdy[0], prod[0]);
    end
    do_op(0, 8'd12, 8'd12, 1'b0, 0, p0, p, lat, bcnt, to);
    tests++;
    if (to || p !== 16'h0090) begin
      fails++;
      $display("FAIL bp_next: got %h exp 0090", p);
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] p0, p;
    int lat, bcnt, n;
    bit to, seen;
    n = 0;
    while (!rdy[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    vld[0] = 1'b1;
    opa[0] = 8'd100;
    opb[0] = 8'd100;
    smode[0] = 1'b0;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if (rdy[0] !== 1'b1 || ovld[0] !== 1'b0 || bsy[0] !== 1'b0
        || prod[0] !== 16'h0000) begin
      fails++;
      $display("FAIL midrun_reset: got rdy=%b ov=%b busy=%b p=%h exp 1 0 0 0000",
               rdy[0], ovld[0], bsy[0], prod[0]);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ovld[0]) seen = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL midrun_abort: got out_valid seen=1 exp 0");
    end
    do_op(0, 8'd6, 8'd7, 1'b0, 0, p0, p, lat, bcnt, to);
    tests++;
    if (to || p !== 16'h002A) begin
      fails++;
      $display("FAIL midrun_next: got %h exp 002A", p);
    end
  endtask

  task automatic test_early_exit();
    logic [15:0] p0, p;
    int lat, bcnt;
    bit to;
    logic [7:0] xs [3];
    logic [7:0] ys [3];
    logic [15:0] es [3];
    int ls [3];
    xs = '{8'd7, 8'h55, 8'd3};
    ys = '{8'd2, 8'd0, 8'h80};
    es = '{16'h000E, 16'h0000, 16'h0180};
    ls = '{2, 1, 8};
    for (int i = 0; i < 3; i++) begin
      do_op(1, xs[i], ys[i], 1'b0, 0, p0, p, lat, bcnt, to);
      tests++;
      if (to || p !== es[i] || lat != ls[i]) begin
        fails++;
        $display("FAIL early_%0d: got p=%h lat=%0d exp %h %0d",
                 i, p, lat, es[i], ls[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] p0, p, e;
    int lat, bcnt, st, el;
    bit to;
    logic [7:0] x, y;
    logic sm;
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      if ((i % 7) == 0) y = 8'($urandom_range(0, 3));
      sm = 1'($urandom);
      st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      e = ref_mul(x, y, sm);
      el = ref_lat(y, sm);
      do_op(1, x, y, sm, st, p0, p, lat, bcnt, to);
      tests++;
      if (to || p !== e || p0 !== e || lat != el) begin
        fails++;
        $display("FAIL rand_%0d: a=%h b=%h s=%b got p=%h/%h lat=%0d exp %h %0d",
                 i, x, y, sm, p0, p, lat, e, el);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0;
      smode[k] = 1'b0;
      ordy[k] = 1'b1;
      opa[k] = '0;
      opb[k] = '0;
    end
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_midrun();
    test_early_exit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_mult_hs.md
Name: seq_mult_hs

Overview:
Parametrised sequential shift-add multiplier, the successor to the fixed 4x4 control-unit/datapath multiplier. It computes WIDTH x WIDTH -> 2*WIDTH products in unsigned or signed mode, selected per operation. Operands enter and results leave through valid/ready handshakes, and the result is held under back-pressure. An optional early-exit mode finishes as soon as the remaining multiplier bits are zero. The block sits between the pin-level wrapper (operand capture, result mux onto outputs) and any host sequencer.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2.
EARLY_EXIT, 0, 1 = end the RUN phase when the remaining multiplier bits are all zero.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
in_valid  input  1  operand set valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier, consumed LSB first.
signed_mode  input  1  1 = a and b are two's complement; sampled at accept.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts product.
product  output  2*WIDTH  result; unsigned or two's complement per the captured mode.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at an edge): state=IDLE; in_ready=1 from the next cycle; out_valid=0; busy=0; product=0; all internal registers cleared. Reset during RUN or DONE aborts the operation and discards it with no output.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Outputs are registered or decoded from state only; there are no combinational input->output paths.
- IDLE -> RUN on an edge with in_valid & in_ready. That edge captures the following:
  - mode = signed_mode.
  - mcand = |a| and mplr = |b| (magnitudes in signed mode, raw values otherwise), in WIDTH-bit unsigned registers.
  - neg = signed_mode & (a[MSB] ^ b[MSB]).
  - acc = 0, count = 0.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH bits unsigned; no overflow special case.
- Each RUN edge:
  - If mplr[0] = 1: acc += mcand << count. The accumulator is 2*WIDTH bits wide; intermediate sums never wrap.
  - mplr >>= 1; count += 1.
- RUN -> DONE on the edge where count reaches WIDTH. With EARLY_EXIT=1, also on the edge where the shifted mplr becomes 0.
- On that final edge: product <= neg ? -(final acc) : final acc, computed modulo 2^(2*WIDTH).
- Latency with EARLY_EXIT=0: the accept edge is T; out_valid is high in the cycle after edge T+WIDTH, exactly WIDTH cycles after accept.
- Latency with EARLY_EXIT=1: 1..WIDTH RUN cycles, equal to max(1, index of the highest set bit of mplr + 1).
- DONE -> IDLE on an edge with out_ready=1; out_valid drops the next cycle.
- While out_ready=0, product and out_valid hold indefinitely.
- in_valid outside IDLE is ignored; the source must hold it, since it is not queued.
- Minimum issue interval is WIDTH+2 cycles (no accept in DONE).
- signed_mode, a and b changing after accept have no effect.
- The product register keeps its last value in IDLE; it is cleared only by reset.

Decomposition:
- Package mult_pkg: state enum {IDLE, RUN, DONE}; localparam functions for counter width, $clog2(WIDTH+1).
- One sub-module, mult_datapath: mcand, mplr and acc registers, the shift-add step and the final conditional negate.
- The parent holds the FSM, count and handshakes, keeping the control/datapath split.

Test Plan:
1. WIDTH=8, unsigned, a=13, b=11, out_ready=1 -> product=0x008F; out_valid exactly 8 cycles after the accept edge, high for 1 cycle; busy high for 9 cycles.
2. Unsigned a=255, b=255 -> 0xFE01. Unsigned a=0, b=200 -> 0x0000.
3. Signed mode:
   - -3*5 -> 0xFFF1.
   - -128*-128 -> 0x4000.
   - -128*127 -> 0xC080.
   - 127*-1 -> 0xFF81.
   - Each case is checked against the signed reference model.
4. Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> product and out_valid stable, in_ready=0, and a pulsed in_valid is ignored. Then out_ready=1 -> IDLE next cycle, and the next op completes correctly.
5. Reset mid-run: drop rst_n for one edge at RUN count=3 -> out_valid never asserts for the aborted op; in_ready=1 the next cycle; product=0. A following 6*7 yields 0x002A.
6. EARLY_EXIT=1:
   - a=7, b=2 -> product 0x000E after 2 RUN cycles.
   - b=0 -> 0x0000 after 1 RUN cycle.
   - b=0x80 -> 8 RUN cycles.
   - Then 1000 random signed/unsigned ops against the model with random out_ready stalls.
